// File: rtl/imem_loader.sv
// imem_loader
//
// Assembles a little-endian byte stream into 32-bit instruction words and
// writes them to an instruction memory, one word at a time, while holding the
// core off the memory. A session is started with start_i from IDLE or DONE
// and ends on a byte flagged last or when the memory is full.
//
// Ports
//   clk_i           single clock, rising edge
//   rst_i           synchronous active-high reset, highest priority
//   start_i         begin a load session (honoured only in IDLE or DONE)
//   byte_valid_i    byte_data_i is valid this cycle
//   byte_data_i     program byte, little-endian within each word
//   byte_last_i     byte_data_i is the final byte of the program
//   byte_ready_o    loader accepts a byte this cycle
//   wr_en_o         single-cycle instruction-memory write strobe
//   wr_addr_o       word address of the write
//   wr_data_o       assembled instruction word
//   cpu_hold_o      holds PC and fetch while the memory is being written
//   done_o          session finished (level)
//   err_o           partial final word or truncation in this session (sticky)
//   words_loaded_o  words written in the current or last session

module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;   // word in flight ends the program
    logic              err_q, err_d;
    logic [ADDR_W:0]   words_q, words_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = last_q;
        err_d        = err_q;
        words_d      = words_q;
        byte_ready_o = 1'b0;
        wr_en_o      = 1'b0;
        cpu_hold_o   = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done_o = (state_q == StDone);
                if (start_i) begin
                    state_d = StLoad;
                    lane_d  = '0;
                    addr_d  = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                end
            end

            StLoad: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
                if (byte_valid_i) begin
                    unique case (lane_q)
                        2'd0: data_d[7:0]   = byte_data_i;
                        2'd1: data_d[15:8]  = byte_data_i;
                        2'd2: data_d[23:16] = byte_data_i;
                        2'd3: data_d[31:24] = byte_data_i;
                        default: ;
                    endcase
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3 || byte_last_i) begin
                        state_d = StWrite;
                        last_d  = byte_last_i;
                        // A program ending mid-word is written zero-padded but flagged.
                        if (byte_last_i && lane_q != 2'd3) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            StWrite: begin
                wr_en_o    = 1'b1;
                cpu_hold_o = 1'b1;
                words_d    = words_q + 1'b1;
                // Saturate so the address never wraps past the top of memory.
                if (addr_q != LastAddr) begin
                    addr_d = addr_q + 1'b1;
                end
                if (last_q) begin
                    state_d = StDone;
                end else if (addr_q == LastAddr) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    state_d = StLoad;
                    lane_d  = '0;
                    data_d  = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wr_addr_o      = addr_q;
    assign wr_data_o      = data_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: byte streams with hand-computed words.

module tb_imem_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .byte_valid_i   (byte_valid),
        .byte_data_i    (byte_data),
        .byte_last_i    (byte_last),
        .byte_ready_o   (byte_ready),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .cpu_hold_o     (cpu_hold),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Write log captured on the falling edge, away from the active edge.
    logic [ADDR_W-1:0] log_addr [256];
    logic [31:0]       log_data [256];
    int                n_wr   = 0;
    int                n_viol = 0;  // wr_en seen with byte_ready=1 or cpu_hold=0

    always @(negedge clk) begin
        if (wr_en) begin
            if (n_wr < 256) begin
                log_addr[n_wr] = wr_addr;
                log_data[n_wr] = wr_data;
            end
            n_wr = n_wr + 1;
            if (byte_ready || !cpu_hold) n_viol = n_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gap);
        int  waited = 0;
        logic acc   = 1'b0;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        while (!acc && waited < 20) begin
            acc = byte_ready;   // ready is registered-state only, stable to the next edge
            @(negedge clk);
            waited++;
        end
        check("byte accepted", {31'b0, acc}, 32'd1);
    endtask

    task automatic idle_inputs();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic wait_done();
        int waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("done reached", {31'b0, done}, 32'd1);
    endtask

    task automatic check_write(input int idx, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        check("write addr", {27'b0, log_addr[idx]}, {27'b0, a});
        check("write data", log_data[idx], d);
    endtask

    logic [7:0] prog_a [8];
    logic [7:0] prog_b [5];
    int         base;
    int         ready_seen;

    initial begin
        prog_a = '{8'h13, 8'h81, 8'h10, 8'h00, 8'hB3, 8'h01, 8'h31, 8'h00};
        prog_b = '{8'h13, 8'h81, 8'h10, 8'h00, 8'h6F};
        rst   = 1'b1;
        start = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst wr_en", {31'b0, wr_en}, 32'd0);
        check("rst wr_addr", {27'b0, wr_addr}, 32'd0);
        check("rst wr_data", wr_data, 32'd0);
        check("rst cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst err", {31'b0, err}, 32'd0);
        check("rst words", {26'b0, words_loaded}, 32'd0);

        // Two full words, valid continuous
        base = n_wr;
        start_session();
        check("load cpu_hold", {31'b0, cpu_hold}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog_a[i], (i == 7), 1'b0);
        idle_inputs();
        wait_done();
        check("a writes", n_wr - base, 32'd2);
        check_write(base, 5'd0, 32'h00108113);
        check_write(base + 1, 5'd1, 32'h003101B3);
        check("a err", {31'b0, err}, 32'd0);
        check("a words", {26'b0, words_loaded}, 32'd2);
        check("a cpu_hold", {31'b0, cpu_hold}, 32'd0);

        // Partial final word: zero-padded, err set
        base = n_wr;
        start_session();
        for (int i = 0; i < 5; i++) send_byte(prog_b[i], (i == 4), 1'b0);
        idle_inputs();
        wait_done();
        check("b writes", n_wr - base, 32'd2);
        check_write(base, 5'd0, 32'h00108113);
        check_write(base + 1, 5'd1, 32'h0000006F);
        check("b err", {31'b0, err}, 32'd1);
        check("b words", {26'b0, words_loaded}, 32'd2);

        // Restart from DONE clears status; valid low every other cycle
        base = n_wr;
        start_session();
        check("restart done", {31'b0, done}, 32'd0);
        check("restart err", {31'b0, err}, 32'd0);
        check("restart words", {26'b0, words_loaded}, 32'd0);
        for (int i = 0; i < 8; i++) send_byte(prog_a[i], (i == 7), 1'b1);
        idle_inputs();
        wait_done();
        check("gap writes", n_wr - base, 32'd2);
        check_write(base, 5'd0, 32'h00108113);
        check_write(base + 1, 5'd1, 32'h003101B3);
        check("gap err", {31'b0, err}, 32'd0);

        // start during LOAD is ignored: word assembly continues
        base = n_wr;
        start_session();
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hB2, 1'b0, 1'b0);
        idle_inputs();
        start_session();
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'hD4, 1'b1, 1'b0);
        idle_inputs();
        wait_done();
        check("mid start writes", n_wr - base, 32'd1);
        check_write(base, 5'd0, 32'hD4C3B2A1);
        check("mid start words", {26'b0, words_loaded}, 32'd1);

        // Truncation: 128 bytes with no last fill memory, further bytes refused
        base = n_wr;
        start_session();
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        ready_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (byte_ready) ready_seen++;
            @(negedge clk);
        end
        idle_inputs();
        check("trunc ready", ready_seen, 32'd0);
        check("trunc done", {31'b0, done}, 32'd1);
        check("trunc writes", n_wr - base, 32'd32);
        for (int k = 0; k < 32; k++) begin
            check_write(base + k, 5'(k),
                        {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)});
        end
        check("trunc err", {31'b0, err}, 32'd1);
        check("trunc words", {26'b0, words_loaded}, 32'd32);

        // Reset mid-word discards the partial word
        base = n_wr;
        start_session();
        for (int i = 0; i < 6; i++) send_byte(prog_a[i], 1'b0, 1'b0);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst byte_ready", {31'b0, byte_ready}, 32'd0);
        check("mid rst wr_en", {31'b0, wr_en}, 32'd0);
        check("mid rst wr_addr", {27'b0, wr_addr}, 32'd0);
        check("mid rst wr_data", wr_data, 32'd0);
        check("mid rst cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("mid rst done", {31'b0, done}, 32'd0);
        check("mid rst err", {31'b0, err}, 32'd0);
        check("mid rst words", {26'b0, words_loaded}, 32'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("mid rst writes", n_wr - base, 32'd1);
        base = n_wr;
        start_session();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        idle_inputs();
        wait_done();
        check("reload writes", n_wr - base, 32'd1);
        check_write(base, 5'd0, 32'h44332211);
        check("reload words", {26'b0, words_loaded}, 32'd1);
        check("reload err", {31'b0, err}, 32'd0);

        check("write side-band", n_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words in the target instruction memory.
REQ-002 Parameter ADDR_W, default 5, width of the word address (log2 DEPTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  program byte stream, little-endian within each word.
REQ-008 byte_last  input  1  qualifies byte_data as the final byte of the program.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 wr_en  output  1  single-cycle write strobe to the instruction memory.
REQ-011 wr_addr  output  ADDR_W  word address of the write.
REQ-012 wr_data  output  32  assembled instruction word.
REQ-013 cpu_hold  output  1  holds the core (PC and fetch) while the memory is being written.
REQ-014 done  output  1  level; session finished.
REQ-015 err  output  1  sticky per session; partial final word or truncation occurred.
REQ-016 words_loaded  output  ADDR_W+1  count of words written in the current or last session.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE, DONE, encoded one register.
REQ-018 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both 1.
REQ-019 IDLE: byte_ready=0, cpu_hold=0; start=1 -> LOAD, clear byte lane, word address, words_loaded, err, done.
REQ-020 DONE: done=1, cpu_hold=0, byte_ready=0; start=1 -> LOAD with the same clearing as REQ-019.
REQ-021 LOAD: byte_ready=1, cpu_hold=1; accepted byte k (k=0..3) SHALL be placed in wr_data[8k+7:8k]; lane counter increments.
REQ-022 Lanes not yet written in the current word SHALL be zero (wr_data cleared at the start of each word).
REQ-023 LOAD -> WRITE on acceptance of lane 3, or on acceptance of any lane with byte_last=1.
REQ-024 byte_last on a lane other than 3 SHALL set err=1; the word is written zero-padded.
REQ-025 WRITE: byte_ready=0, wr_en=1 for exactly one cycle, wr_addr=current word address, wr_data=assembled word, cpu_hold=1.
REQ-026 On leaving WRITE: word address +1 and words_loaded +1.
REQ-027 WRITE -> DONE if the word was marked last; else if wr_addr=DEPTH-1, -> DONE with err=1 (truncation, no address wrap); else -> LOAD.
REQ-028 Byte-to-write latency: wr_en SHALL assert the cycle after the 4th (or last) byte is accepted.
REQ-029 start SHALL be ignored in LOAD and WRITE; byte_valid SHALL be ignored in IDLE, WRITE, DONE.
REQ-030 wr_en SHALL never assert outside WRITE; wr_addr SHALL never exceed DEPTH-1.
REQ-031 Sustained throughput: one word per 5 cycles with byte_valid held high.

Reset
REQ-032 rst=1 SHALL force IDLE on the next edge, with priority over all other inputs, including mid-LOAD or in WRITE.
REQ-033 Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, words_loaded=0, lane counter=0.
REQ-034 A partially assembled word at reset SHALL be discarded, never written.

Verification
REQ-035 start; bytes 13,81,10,00,B3,01,31,00 (last on 8th), valid continuous -> writes [0]=00108113, [1]=003101B3; done=1, err=0, words_loaded=2, cpu_hold falls with done.
REQ-036 Same stream with byte_valid low every other cycle -> identical writes; exactly 2 wr_en pulses; byte_ready low in WRITE cycles.
REQ-037 start; bytes 13,81,10,00,6F (last on 5th) -> [0]=00108113, [1]=0000006F; err=1, words_loaded=2.
REQ-038 start; 132 bytes with no last -> 32 writes at addr 0..31, DONE after addr 31, err=1, words_loaded=32, remaining bytes not accepted.
REQ-039 start; 6 bytes; rst pulse -> IDLE, no write for word 1, all outputs at reset values; new start reloads from addr 0.
REQ-040 start asserted during LOAD and in DONE -> ignored in LOAD; from DONE it restarts with done=0, err=0, words_loaded=0.
